// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: round-robin arbitrated update controller for HEX0..HEX7.
// A granted 32-bit value is latched and written one digit per cycle, HEX0 first.
// Optional build macro HEX_LZ_BLANK_EN: blank leading-zero digits (HEX0 always shown).
module hex_display_ctrl #(
   parameter int NREQ           = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                 CLOCK_50,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [32*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 busy,
   output logic [2:0]           grant_id,
   output logic [6:0]           HEX0,
   output logic [6:0]           HEX1,
   output logic [6:0]           HEX2,
   output logic [6:0]           HEX3,
   output logic [6:0]           HEX4,
   output logic [6:0]           HEX5,
   output logic [6:0]           HEX6,
   output logic [6:0]           HEX7
);

   typedef enum logic {S_IDLE, S_UPDATE} state_t;

   // Decoder works in active-low; XOR with this mask flips polarity for the board.
   localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic [6:0] BLANK   = 7'h7F ^ SEG_INV;

   state_t            r_state, w_state_nxt;
   logic [2:0]        r_rr;
   logic [2:0]        r_dcnt;
   logic [31:0]       r_shadow;
   logic [2:0]        r_grant_id;
   logic              r_busy;
   logic [7:0][6:0]   r_hex;

   logic              w_found;
   logic [2:0]        w_win;
   logic [NREQ-1:0]   w_grant_oh;
   logic [31:0]       w_sel_data;
   logic              w_hs;
   logic [3:0]        w_nib;
   logic              w_lz;
   logic [6:0]        w_seg;

   function automatic logic [6:0] f_decode(input logic [3:0] n);
      case (n)
         4'h0: f_decode = 7'h40;  4'h1: f_decode = 7'h79;
         4'h2: f_decode = 7'h24;  4'h3: f_decode = 7'h30;
         4'h4: f_decode = 7'h19;  4'h5: f_decode = 7'h12;
         4'h6: f_decode = 7'h02;  4'h7: f_decode = 7'h78;
         4'h8: f_decode = 7'h00;  4'h9: f_decode = 7'h10;
         4'hA: f_decode = 7'h08;  4'hB: f_decode = 7'h03;
         4'hC: f_decode = 7'h46;  4'hD: f_decode = 7'h21;
         4'hE: f_decode = 7'h06;  default: f_decode = 7'h0E;
      endcase
   endfunction

   // Round-robin search: first valid requester at or after r_rr, wrapping.
   always_comb begin
      w_found    = 1'b0;
      w_win      = 3'd0;
      w_grant_oh = '0;
      w_sel_data = 32'd0;
      for (int k = 0; k < NREQ; k++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (!w_found && req_valid[j] && (j == (int'(r_rr) + k) % NREQ)) begin
               w_found       = 1'b1;
               w_win         = 3'(j);
               w_grant_oh[j] = 1'b1;
               w_sel_data    = req_data[32*j +: 32];
            end
         end
      end
   end

   assign req_ready = (r_state == S_IDLE) ? w_grant_oh : '0;
   assign w_hs      = |(req_valid & req_ready);

   // Next-state: one grant moves to UPDATE, the eighth digit returns to IDLE.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_hs) w_state_nxt = S_UPDATE;
         S_UPDATE: if (r_dcnt == 3'd7) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Segment pattern for the digit currently being written.
   always_comb begin
      w_nib = r_shadow[{r_dcnt, 2'b00} +: 4];
`ifdef HEX_LZ_BLANK_EN
      w_lz  = (r_dcnt != 3'd0) && ((r_shadow >> {r_dcnt, 2'b00}) == 32'd0);
`else
      w_lz  = 1'b0;
`endif
      w_seg = w_lz ? BLANK : (f_decode(w_nib) ^ SEG_INV);
   end

   // State register.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Grant bookkeeping, digit counter and busy flag.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_rr       <= 3'd0;
         r_dcnt     <= 3'd0;
         r_shadow   <= 32'd0;
         r_grant_id <= 3'd0;
         r_busy     <= 1'b0;
      end else if (w_hs) begin
         r_shadow   <= w_sel_data;
         r_grant_id <= w_win;
         r_rr       <= 3'((int'(w_win) + 1) % NREQ);
         r_dcnt     <= 3'd0;
         r_busy     <= 1'b1;
      end else if (r_state == S_UPDATE) begin
         r_dcnt <= r_dcnt + 3'd1;
         if (r_dcnt == 3'd7) r_busy <= 1'b0;
      end
   end

   // Digit registers: one digit per UPDATE cycle, others hold.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n)                    r_hex         <= {8{BLANK}};
      else if (r_state == S_UPDATE)  r_hex[r_dcnt] <= w_seg;
   end

   assign busy     = r_busy;
   assign grant_id = r_grant_id;
   assign HEX0     = r_hex[0];
   assign HEX1     = r_hex[1];
   assign HEX2     = r_hex[2];
   assign HEX3     = r_hex[3];
   assign HEX4     = r_hex[4];
   assign HEX5     = r_hex[5];
   assign HEX6     = r_hex[6];
   assign HEX7     = r_hex[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Scoreboard bench for hex_display_ctrl: driver predicts the winner and value,
// monitor checks grant, timing, busy and digit-by-digit display contents.
module tb_hex_display_ctrl;

   localparam int NREQ = 2;
   localparam logic [6:0] SEG_TBL [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      int          id;
      logic [31:0] val;
   } exp_t;

   logic                 clk;
   logic                 rst_n;
   logic [NREQ-1:0]      req_valid;
   logic [32*NREQ-1:0]   req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 busy;
   logic [2:0]           grant_id;
   logic [6:0]           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
   logic [55:0]          hexv;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   exp_t        q[$];
   bit [NREQ-1:0] pend;
   logic [31:0] val[NREQ];
   int          rr_m;
   logic [7:0][6:0] disp;
   bit          have_prev;
   int          prev_cyc;
   exp_t        m_e;
   bit          m_ok;

   hex_display_ctrl #(.NREQ(NREQ), .SEG_ACTIVE_LOW(1'b1)) dut (
      .CLOCK_50(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .busy(busy), .grant_id(grant_id),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
      .HEX4(HEX4), .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7));

   assign hexv = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Digit k of value v as the board should show it.
   function automatic logic [6:0] exp_seg(input logic [31:0] v, input int k);
      logic [3:0] n;
      n = 4'((v >> (4 * k)) & 32'hF);
`ifdef HEX_LZ_BLANK_EN
      if (k > 0 && (v >> (4 * k)) == 32'd0) return 7'h7F;
`endif
      return SEG_TBL[n];
   endfunction

   // Present pending requests, predict the winner, wait for its handshake.
   task automatic one_txn();
      int w;
      bit ok;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]         = pend[i];
         req_data[32*i +: 32] = val[i];
      end
      w = -1;
      for (int k = 0; k < NREQ; k++)
         if (w < 0 && pend[(rr_m + k) % NREQ]) w = (rr_m + k) % NREQ;
      q.push_back('{w, val[w]});
      rr_m = (w + 1) % NREQ;
      ok = 1'b0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clk);
         if ((req_valid & req_ready) != '0) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL hs_timeout: got no handshake expected grant %0d", w);
      end
      @(posedge clk); #1;
      // Winner drops its request and scribbles its data; latched value must hold.
      pend[w]              = 1'b0;
      val[w]               = $urandom;
      req_valid[w]         = 1'b0;
      req_data[32*w +: 32] = val[w];
   endtask

   // Monitor: on every observed handshake, pop and check the whole update.
   initial begin
      disp      = {8{7'h7F}};
      have_prev = 1'b0;
      prev_cyc  = 0;
      forever begin
         @(negedge clk);
         if (rst_n && (req_valid & req_ready) != '0) begin
            m_ok = (q.size() != 0);
            chk("exp_available", 64'(m_ok), 64'd1);
            if (m_ok) begin
               m_e = q.pop_front();
               chk("grant_onehot", 64'(req_ready), 64'(NREQ'(1) << m_e.id));
               if (have_prev) chk("hs_gap", 64'(cyc - prev_cyc), 64'd9);
               prev_cyc  = cyc;
               have_prev = 1'b1;
               @(posedge clk); #1;
               chk("busy_start", 64'(busy), 64'd1);
               chk("grant_id", 64'(grant_id), 64'(m_e.id));
               chk("ready_upd", 64'(req_ready), 64'd0);
               for (int k = 0; k < 8; k++) begin
                  @(posedge clk); #1;
                  if (!rst_n) begin
                     disp      = {8{7'h7F}};
                     have_prev = 1'b0;
                     break;
                  end
                  disp[k] = exp_seg(m_e.val, k);
                  chk("hex", 64'(hexv), 64'(disp));
                  chk("busy", 64'(busy), (k < 7) ? 64'd1 : 64'd0);
                  if (k < 7) chk("ready_upd", 64'(req_ready), 64'd0);
               end
            end
         end
      end
   end

   // Driver.
   initial begin
      logic [31:0] dir [5];
      int i;
      dir = '{32'h0123_4567, 32'hFEDC_BA98, 32'h7654_3210, 32'h0000_00A5, 32'h0};
      rst_n = 1'b0; req_valid = '0; req_data = '0; rr_m = 0; pend = '0;
      for (int k = 0; k < NREQ; k++) val[k] = 32'd0;
      repeat (3) @(posedge clk); #1;
      chk("rst_hex", 64'(hexv), 64'({8{7'h7F}}));
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_gid", 64'(grant_id), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed values on requester 0; first one gets data churn mid-update.
      for (int d = 0; d < 5; d++) begin
         pend[0] = 1'b1; val[0] = dir[d];
         one_txn();
         if (d == 0) repeat (3) @(posedge clk);
         if (d == 0) #1;
      end

      // Both requesters continuously valid: grants must alternate.
      pend = '1; val[0] = 32'hAAAA_AAAA; val[1] = 32'h5555_5555;
      for (int n = 0; n < 4; n++) begin
         i = rr_m;
         one_txn();
         pend[i] = 1'b1;
         val[i]  = (i == 0) ? 32'hAAAA_AAAA : 32'h5555_5555;
      end

      // Reset pulse mid-update of FFFF_FFFF.
      pend = '0; pend[0] = 1'b1; val[0] = 32'hFFFF_FFFF;
      one_txn();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_hex", 64'(hexv), 64'({8{7'h7F}}));
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_gid", 64'(grant_id), 64'd0);
      pend = '0; req_valid = '0; rr_m = 0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      pend[1] = 1'b1; val[1] = 32'h1234_5678;
      one_txn();

      // Random traffic, some values with leading zeros.
      for (int n = 0; n < 30; n++) begin
         for (int k = 0; k < NREQ; k++)
            if (!pend[k] && $urandom_range(0, 1) == 1) begin
               pend[k] = 1'b1;
               val[k]  = $urandom >> $urandom_range(0, 31);
            end
         if (pend == '0) begin
            i = $urandom_range(0, NREQ - 1);
            pend[i] = 1'b1;
            val[i]  = $urandom;
         end
         one_txn();
      end

      repeat (12) @(posedge clk); #1;
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
